// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state type, default timing constants and a sizing helper for the PLL lock sequencer
package pll_seq_pkg;
   typedef enum logic [2:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
   localparam int DEF_RST_HOLD_CYCLES     = 16;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES         = 3;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0
//   clk   - destination clock
//   rst_n - async active-low reset
//   d     - asynchronous input
//   q     - synchronized output
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for a stable lock, retries on timeout and releases sys_rst_n
//   refclk      - 50 MHz PLL reference, sole clock
//   rst_n       - async active-low reset
//   pll_locked  - raw PLL lock, asynchronous to refclk
//   restart_req - single-cycle request to re-run the sequence
//   pll_rst     - active-high PLL reset
//   sys_rst_n   - active-low reset for PLL-clocked logic
//   ready       - high only in RUN
//   fail        - high only in FAIL
//   retry_cnt   - failed attempts in this sequence, saturating at 3
//   loss_cnt    - lock-loss events from RUN, saturating at 255 (only with PLL_SEQ_LOSS_CNT_EN)
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
   ,
   output logic [7:0] loss_cnt
`endif
);
   localparam int CW = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
   // at least 2 bits so the saturated 2-bit view can always be sliced out
   localparam int RW = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);
   state_t        state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [RW-1:0] tries, nxt_tries, tries_inc;
   logic          locked_s;
   sync_2ff u_sync (.clk(refclk), .rst_n(rst_n), .d(pll_locked), .q(locked_s));
   assign tries_inc = tries + 1'b1;
   // the lock sample that moves WAIT_LOCK to STABLE is the first of the consecutive run, so STABLE starts at 1
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 1'b1;
      nxt_tries = tries;
      if (restart_req) begin
         nxt_state = PLL_RESET;
         nxt_cnt   = '0;
         nxt_tries = '0;
      end else begin
         case (state)
            PLL_RESET:
               if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
                  nxt_state = WAIT_LOCK;
                  nxt_cnt   = '0;
               end
            WAIT_LOCK:
               if (locked_s) begin
                  nxt_state = (LOCK_STABLE_CYCLES == 1) ? RUN : STABLE;
                  nxt_cnt   = CW'(1);
               end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  nxt_tries = tries_inc;
                  nxt_state = (tries_inc == RW'(MAX_RETRIES)) ? FAIL : PLL_RESET;
                  nxt_cnt   = '0;
               end
            STABLE:
               if (!locked_s) begin
                  nxt_state = WAIT_LOCK;
                  nxt_cnt   = '0;
               end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                  nxt_state = RUN;
                  nxt_cnt   = '0;
               end
            RUN: begin
               nxt_cnt = '0;
               if (!locked_s) begin
                  nxt_state = PLL_RESET;
                  nxt_tries = '0;
               end
            end
            default: nxt_cnt = '0;
         endcase
      end
   end
   // outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge refclk or negedge rst_n)
      if (!rst_n) begin
         state     <= PLL_RESET;
         cnt       <= '0;
         tries     <= '0;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 2'd0;
      end else begin
         state     <= nxt_state;
         cnt       <= nxt_cnt;
         tries     <= nxt_tries;
         pll_rst   <= (nxt_state == PLL_RESET) || (nxt_state == FAIL);
         sys_rst_n <= nxt_state == RUN;
         ready     <= nxt_state == RUN;
         fail      <= nxt_state == FAIL;
         retry_cnt <= (nxt_tries > RW'(3)) ? 2'd3 : nxt_tries[1:0];
      end
`ifdef PLL_SEQ_LOSS_CNT_EN
   // a restart from RUN is not a lock loss
   always_ff @(posedge refclk or negedge rst_n)
      if (!rst_n) loss_cnt <= 8'd0;
      else if (state == RUN && !locked_s && !restart_req && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed stimulus with a per-cycle behavioural model and hand-computed timing checks
module tb_pll_lock_sequencer;
   localparam int RH = 4, TO = 32, ST = 8, MR = 3;
   localparam int P_HOLD = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_DEAD = 4;
   logic       refclk = 1'b0, rst_n = 1'b1, pll_locked = 1'b0, restart_req = 1'b0;
   logic       pll_rst, sys_rst_n, ready, fail;
   logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif
   int checks = 0, passes = 0, n = 0;
   bit cmp_en = 1'b0;
   logic [1:0] m_sync;
   int m_ph, m_left, m_streak, m_tries, m_loss;
   pll_lock_sequencer #(
      .RST_HOLD_CYCLES(RH), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(ST), .MAX_RETRIES(MR)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart_req(restart_req),
      .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail), .retry_cnt(retry_cnt)
`ifdef PLL_SEQ_LOSS_CNT_EN
      , .loss_cnt(loss_cnt)
`endif
   );
   always #5 refclk = ~refclk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask
   // model: phase plus cycles left in the timed phase, and a run length of consecutive lock samples
   always @(posedge refclk or negedge rst_n)
      if (!rst_n) begin
         m_sync <= 2'b00; m_ph <= P_HOLD; m_left <= RH; m_streak <= 0; m_tries <= 0; m_loss <= 0;
      end else begin
         m_sync <= {m_sync[0], pll_locked};
         if (restart_req) begin
            m_ph <= P_HOLD; m_left <= RH; m_tries <= 0;
         end else case (m_ph)
            P_HOLD: if (m_left == 1) begin m_ph <= P_WAIT; m_left <= TO; end else m_left <= m_left - 1;
            P_WAIT:
               if (m_sync[1]) begin m_streak <= 1; m_ph <= (ST == 1) ? P_RUN : P_SETTLE; end
               else if (m_left == 1) begin
                  m_tries <= m_tries + 1; m_ph <= (m_tries + 1 == MR) ? P_DEAD : P_HOLD; m_left <= RH;
               end else m_left <= m_left - 1;
            P_SETTLE:
               if (!m_sync[1]) begin m_ph <= P_WAIT; m_left <= TO; end
               else begin m_streak <= m_streak + 1; if (m_streak + 1 == ST) m_ph <= P_RUN; end
            P_RUN:
               if (!m_sync[1]) begin
                  m_ph <= P_HOLD; m_left <= RH; m_tries <= 0; m_loss <= (m_loss == 255) ? 255 : m_loss + 1;
               end
            default: ;
         endcase
      end
   always @(negedge refclk)
      if (cmp_en) begin
         chk("cyc_pll_rst", int'(pll_rst), int'(m_ph == P_HOLD || m_ph == P_DEAD));
         chk("cyc_sys_rst_n", int'(sys_rst_n), int'(m_ph == P_RUN));
         chk("cyc_ready", int'(ready), int'(m_ph == P_RUN));
         chk("cyc_fail", int'(fail), int'(m_ph == P_DEAD));
         chk("cyc_retry_cnt", int'(retry_cnt), (m_tries > 3) ? 3 : m_tries);
`ifdef PLL_SEQ_LOSS_CNT_EN
         chk("cyc_loss_cnt", int'(loss_cnt), m_loss);
`endif
      end
   task automatic run_len(input logic lvl, output int len);
      len = 0;
      while (pll_rst === lvl && len < 200) begin len++; @(negedge refclk); end
   endtask
   task automatic wait_ready(output int len);
      len = 0;
      do begin @(negedge refclk); len++; end while (!ready && len < 200);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      #1 rst_n = 1'b0;
      #2 cmp_en = 1'b1;
      repeat (3) @(negedge refclk);
      chk("rst_pll_rst", int'(pll_rst), 1);
      chk("rst_sys_rst_n", int'(sys_rst_n), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_retry", int'(retry_cnt), 0);
      rst_n = 1'b1;
      run_len(1'b1, n); chk("hold_len", n, 4);
      repeat (5) @(negedge refclk);
      pll_locked = 1'b1;
      wait_ready(n); chk("lock_to_run", n, 10);
      chk("run_sys_rst_n", int'(sys_rst_n), 1);
      @(negedge refclk);
      pll_locked = 1'b0;
      n = 0;
      do begin @(negedge refclk); n++; end while (!pll_rst && n < 50);
      chk("loss_to_pll_rst", n, 3);
      chk("loss_sys_rst_n", int'(sys_rst_n), 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
      chk("loss_cnt_one", int'(loss_cnt), 1);
`endif
      for (int k = 1; k <= 3; k++) begin
         run_len(1'b1, n); chk("retry_pulse_len", n, 4);
         run_len(1'b0, n); chk("retry_wait_len", n, 32);
         chk("retry_cnt_step", int'(retry_cnt), k);
         chk("fail_step", int'(fail), int'(k == 3));
      end
      repeat (40) @(negedge refclk);
      chk("fail_sticky", int'(fail), 1);
      chk("fail_pll_rst", int'(pll_rst), 1);
      restart_req = 1'b1;
      @(negedge refclk);
      restart_req = 1'b0;
      pll_locked = 1'b1;
      chk("restart_retry", int'(retry_cnt), 0);
      chk("restart_fail", int'(fail), 0);
      chk("restart_pll_rst", int'(pll_rst), 1);
      wait_ready(n); chk("restart_to_run", n, 12);
      restart_req = 1'b1;
      @(negedge refclk);
      restart_req = 1'b0;
      repeat (7) @(negedge refclk);
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      n = 8;
      while (!ready && n < 80) begin @(negedge refclk); n++; end
      chk("glitch_to_run", n, 18);
      pll_locked = 1'b0;
      restart_req = 1'b1;
      @(negedge refclk);
      restart_req = 1'b0;
      repeat (37) @(negedge refclk);
      chk("first_timeout_retry", int'(retry_cnt), 1);
      repeat (34) @(negedge refclk);
      restart_req = 1'b1;
      @(negedge refclk);
      restart_req = 1'b0;
      chk("restart_at_timeout_retry", int'(retry_cnt), 0);
      chk("restart_at_timeout_pll_rst", int'(pll_rst), 1);
      @(negedge refclk);
      restart_req = 1'b1;
      @(negedge refclk);
      restart_req = 1'b0;
      run_len(1'b1, n); chk("hold_restarted_len", n, 4);
      repeat (40) @(negedge refclk);
      chk("pre_abort_retry", int'(retry_cnt), 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
      chk("loss_cnt_kept", int'(loss_cnt), 1);
`endif
      #2 rst_n = 1'b0;
      #1;
      chk("abort_pll_rst", int'(pll_rst), 1);
      chk("abort_retry", int'(retry_cnt), 0);
      repeat (2) @(negedge refclk);
      rst_n = 1'b1;
      run_len(1'b1, n); chk("post_abort_hold_len", n, 4);
      chk("post_abort_retry", int'(retry_cnt), 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
      chk("loss_cnt_cleared", int'(loss_cnt), 0);
`endif
      repeat (3) @(negedge refclk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
